// File: rtl/irb_extmem_arbiter.sv
// Round-robin owner arbiter for the shared external-memory port.
// Ports: per-requester req/wr/addr/wdata/rel in, valid out; memory side out; grant/status out.
module irb_extmem_arbiter #(
  parameter int NREQ    = 4,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_i,
  input  logic [NREQ-1:0]         wr_i,
  input  logic [NREQ*AW-1:0]      addr_i,
  input  logic [NREQ*DW-1:0]      wdata_i,
  input  logic [NREQ-1:0]         rel_i,
  output logic [NREQ-1:0]         valid_o,
  output logic [DW-1:0]           rdata_o,
  output logic                    request_extmem,
  output logic                    write_extmem,
  output logic [AW-1:0]           addr_extmem,
  output logic [DW-1:0]           w_data,
  input  logic                    valid_extmem,
  input  logic [DW-1:0]           data_extmem,
  output logic [NREQ-1:0]         gnt_o,
  output logic [$clog2(NREQ)-1:0] owner_o,
  output logic                    busy,
  output logic                    timeout_err,
  output logic [$clog2(NREQ)-1:0] timeout_id
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, OWN, GAP} state_t;

  state_t          state, state_n;
  logic [NREQ-1:0] gnt_n;
  logic [IW-1:0]   owner_n, rr_ptr, rr_n, tid_n, pick;
  logic [CW-1:0]   idle_cnt, idle_n;
  logic [NREQ-1:0] rot;
  logic [IW:0]     sum;
  logic            found, owned, owned_n, terr_n;
  logic            oreq, expire;

  assign oreq    = req_i[owner_o];
  assign rdata_o = data_extmem;
  assign busy    = (state != IDLE);

  // Only idle owner cycles count; the idle_cnt+1 term fires on the
  // TIMEOUT-th consecutive idle cycle.
  assign expire = (TIMEOUT > 0) && !oreq &&
                  (idle_cnt + 1'b1 == CW'(TIMEOUT));

  // Rotate requests so bit 0 is rr_ptr; lowest set bit wins.
  always_comb begin
    rot   = NREQ'({req_i, req_i} >> rr_ptr);
    found = |req_i;
    pick  = '0;
    sum   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        sum = {1'b0, rr_ptr} + (IW+1)'(i);
        if (sum >= (IW+1)'(NREQ))
          sum = sum - (IW+1)'(NREQ);
        pick = sum[IW-1:0];
      end
    end
  end

  always_comb begin
    state_n = state;
    gnt_n   = gnt_o;
    owner_n = owner_o;
    rr_n    = rr_ptr;
    idle_n  = idle_cnt;
    terr_n  = timeout_err;
    tid_n   = timeout_id;
    owned_n = owned;
    unique case (state)
      IDLE: begin
        idle_n = '0;
        if (found) begin
          state_n = OWN;
          gnt_n   = NREQ'(1) << pick;
          owner_n = pick;
          owned_n = 1'b1;
        end
      end
      OWN: begin
        idle_n = oreq ? '0 : idle_cnt + 1'b1;
        if (rel_i[owner_o] || expire) begin
          state_n = GAP;
          gnt_n   = '0;
          idle_n  = '0;
          rr_n    = (owner_o == IW'(NREQ - 1)) ?
                    '0 : owner_o + 1'b1;
          if (expire) begin
            terr_n = 1'b1;
            tid_n  = owner_o;
          end
        end
      end
      GAP: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      gnt_o       <= '0;
      owner_o     <= '0;
      rr_ptr      <= '0;
      idle_cnt    <= '0;
      timeout_err <= 1'b0;
      timeout_id  <= '0;
      owned       <= 1'b0;
    end else begin
      state       <= state_n;
      gnt_o       <= gnt_n;
      owner_o     <= owner_n;
      rr_ptr      <= rr_n;
      idle_cnt    <= idle_n;
      timeout_err <= terr_n;
      timeout_id  <= tid_n;
      owned       <= owned_n;
    end
  end

  // Request side is gated by rst so nothing leaks in the reset cycle.
  always_comb begin
    request_extmem = 1'b0;
    write_extmem   = 1'b0;
    valid_o        = '0;
    if (state == OWN && !rst) begin
      request_extmem   = oreq;
      write_extmem     = oreq & wr_i[owner_o];
      valid_o[owner_o] = valid_extmem;
    end
  end

  // Address/data keep following the last owner's slice after release.
  always_comb begin
    addr_extmem = '0;
    w_data      = '0;
    if (owned) begin
      addr_extmem = addr_i[int'(owner_o) * AW +: AW];
      w_data      = wdata_i[int'(owner_o) * DW +: DW];
    end
  end

endmodule

// File: tb/tb_irb_extmem_arbiter.sv
// Bench for irb_extmem_arbiter: two instances (TIMEOUT 8 and 0) vs a
// cycle model, plus directed literal checks.
module tb_irb_extmem_arbiter;

  localparam int NREQ = 4;
  localparam int AW   = 32;
  localparam int DW   = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic [NREQ-1:0]  req, wr, rel;
  logic [NREQ*AW-1:0] addr;
  logic [NREQ*DW-1:0] wdata;
  logic             vld;
  logic [DW-1:0]    dat;

  logic [NREQ-1:0]  valid [2];
  logic [DW-1:0]    rdata [2];
  logic             reqx  [2];
  logic             wrx   [2];
  logic [AW-1:0]    addrx [2];
  logic [DW-1:0]    wdx   [2];
  logic [NREQ-1:0]  gnt   [2];
  logic [1:0]       owner [2];
  logic             busy  [2];
  logic             terr  [2];
  logic [1:0]       tid   [2];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  irb_extmem_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .TIMEOUT(8)) u_dut8 (
    .clk(clk), .rst(rst), .req_i(req), .wr_i(wr), .addr_i(addr),
    .wdata_i(wdata), .rel_i(rel), .valid_o(valid[0]), .rdata_o(rdata[0]),
    .request_extmem(reqx[0]), .write_extmem(wrx[0]),
    .addr_extmem(addrx[0]), .w_data(wdx[0]), .valid_extmem(vld),
    .data_extmem(dat), .gnt_o(gnt[0]), .owner_o(owner[0]),
    .busy(busy[0]), .timeout_err(terr[0]), .timeout_id(tid[0])
  );

  irb_extmem_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .TIMEOUT(0)) u_dut0 (
    .clk(clk), .rst(rst), .req_i(req), .wr_i(wr), .addr_i(addr),
    .wdata_i(wdata), .rel_i(rel), .valid_o(valid[1]), .rdata_o(rdata[1]),
    .request_extmem(reqx[1]), .write_extmem(wrx[1]),
    .addr_extmem(addrx[1]), .w_data(wdx[1]), .valid_extmem(vld),
    .data_extmem(dat), .gnt_o(gnt[1]), .owner_o(owner[1]),
    .busy(busy[1]), .timeout_err(terr[1]), .timeout_id(tid[1])
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: who owns the port, whether a gap cycle is pending, and the
  // round-robin start point, per instance.
  int m_own [2], m_last [2], m_rr [2], m_idle [2], m_tid [2];
  bit m_gap [2], m_terr [2];
  bit m_live = 0;

  function automatic int to_of(input int d);
    return (d == 0) ? 8 : 0;
  endfunction

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        m_own[d] = -1; m_last[d] = -1; m_rr[d] = 0; m_idle[d] = 0;
        m_tid[d] = 0; m_gap[d] = 0; m_terr[d] = 0;
      end else if (m_gap[d]) begin
        m_gap[d] = 0;
      end else if (m_own[d] >= 0) begin
        int o;
        bit ex;
        o = m_own[d];
        m_idle[d] = req[o] ? 0 : m_idle[d] + 1;
        ex = (to_of(d) > 0) && (m_idle[d] == to_of(d));
        if (rel[o] || ex) begin
          if (ex) begin
            m_terr[d] = 1;
            m_tid[d] = o;
          end
          m_rr[d] = (o + 1) % NREQ;
          m_own[d] = -1;
          m_gap[d] = 1;
          m_idle[d] = 0;
        end
      end else begin
        for (int k = 0; k < NREQ; k++)
          if (m_own[d] < 0 && req[(m_rr[d] + k) % NREQ]) begin
            m_own[d] = (m_rr[d] + k) % NREQ;
            m_last[d] = m_own[d];
          end
      end
    end
    m_live = 1;
  end

  always @(negedge clk) begin
    if (m_live) begin
      for (int d = 0; d < 2; d++) begin
        int o;
        logic [NREQ-1:0] e_gnt, e_val;
        logic e_req, e_wr;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wd;
        o = m_own[d];
        e_gnt = '0; e_val = '0; e_req = 0; e_wr = 0;
        e_addr = '0; e_wd = '0;
        if (o >= 0) begin
          e_gnt[o] = 1'b1;
          if (!rst) begin
            e_req = req[o];
            e_wr = req[o] & wr[o];
            e_val[o] = vld;
          end
        end
        if (m_last[d] >= 0) begin
          e_addr = addr[m_last[d]*AW +: AW];
          e_wd = wdata[m_last[d]*DW +: DW];
        end
        chk($sformatf("d%0d.gnt", d), gnt[d], e_gnt);
        chk($sformatf("d%0d.owner", d), owner[d],
            (m_last[d] < 0) ? 0 : m_last[d]);
        chk($sformatf("d%0d.busy", d), busy[d], (o >= 0) || m_gap[d]);
        chk($sformatf("d%0d.request", d), reqx[d], e_req);
        chk($sformatf("d%0d.write", d), wrx[d], e_wr);
        chk($sformatf("d%0d.valid", d), valid[d], e_val);
        chk($sformatf("d%0d.rdata", d), rdata[d], dat);
        chk($sformatf("d%0d.addr", d), addrx[d], e_addr);
        chk($sformatf("d%0d.wdata", d), wdx[d], e_wd);
        chk($sformatf("d%0d.terr", d), terr[d], m_terr[d]);
        chk($sformatf("d%0d.tid", d), tid[d], m_tid[d]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1; req = '0; wr = '0; rel = '0; vld = 0; dat = '0;
    tick();
    rst = 0;
  endtask

  int order[$];
  int exp_order [5] = '{0, 1, 2, 3, 0};

  initial begin
    rst = 1; req = '0; wr = '0; rel = '0; vld = 0; dat = '0;
    for (int k = 0; k < NREQ; k++) begin
      addr[k*AW +: AW] = 32'h100 * (k + 1);
      wdata[k*DW +: DW] = 32'hA000 + k;
    end
    tick(); tick();
    rst = 0;
    @(negedge clk);
    chk("rst_gnt", gnt[0], 4'b0000);
    chk("rst_busy", busy[0], 1'b0);
    chk("rst_addr", addrx[0], 32'h0);
    chk("rst_terr", terr[0], 1'b0);

    // single requester
    tick(); req = 4'b0001;
    tick(); @(negedge clk);
    chk("single_gnt", gnt[0], 4'b0001);
    chk("single_addr", addrx[0], 32'h100);
    chk("single_req", reqx[0], 1'b1);
    tick(); tick(); tick(); tick();
    rel = 4'b0001; req = '0;
    tick(); rel = '0; @(negedge clk);
    chk("single_gap_busy", busy[0], 1'b1);
    tick(); @(negedge clk);
    chk("single_idle_busy", busy[0], 1'b0);

    // contention, each owner holds three cycles
    do_reset();
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      int w;
      w = 0;
      while (gnt[0] == '0 && w < 10) begin
        tick();
        w++;
      end
      if (gnt[0] == '0) begin
        chk("cont_wait", 1'b0, 1'b1);
      end else begin
        for (int k = 0; k < NREQ; k++)
          if (gnt[0][k]) order.push_back(k);
        tick(); tick();
        rel = gnt[0];
        tick();
        rel = '0;
      end
    end
    req = '0;
    chk("order_len", order.size(), 5);
    for (int i = 0; i < 5 && i < order.size(); i++)
      chk($sformatf("order%0d", i), order[i], exp_order[i]);

    // routing isolation
    do_reset();
    req = 4'b0100;
    tick();
    req = 4'b1111; wr = 4'b1011; vld = 1; dat = 32'hDEADBEEF;
    @(negedge clk);
    chk("route_valid", valid[0], 4'b0100);
    chk("route_rdata", rdata[0], 32'hDEADBEEF);
    chk("route_nowrite", wrx[0], 1'b0);
    tick(); wr = 4'b1111;
    @(negedge clk);
    chk("route_write", wrx[0], 1'b1);
    tick(); vld = 0; rel = 4'b0100;
    tick(); rel = '0; wr = '0; req = '0;
    tick(); tick(); tick();

    // stray release and paused owner
    do_reset();
    req = 4'b0010;
    tick();
    rel = 4'b0001;
    tick(); rel = '0;
    @(negedge clk);
    chk("stray_gnt", gnt[0], 4'b0010);
    req = '0;
    repeat (10) tick();
    @(negedge clk);
    chk("pause_gnt_to0", gnt[1], 4'b0010);
    chk("pause_busy_to0", busy[1], 1'b1);

    // watchdog
    do_reset();
    req = 4'b1000;
    tick(); @(negedge clk);
    chk("wd_gnt", gnt[0], 4'b1000);
    req = 4'b0001;
    repeat (8) tick();
    @(negedge clk);
    chk("wd_released", gnt[0], 4'b0000);
    chk("wd_terr", terr[0], 1'b1);
    chk("wd_tid", tid[0], 2'd3);
    tick(); tick(); @(negedge clk);
    chk("wd_next_gnt", gnt[0], 4'b0001);
    chk("wd_terr_to0", terr[1], 1'b0);

    // reset mid-transfer with rr_ptr away from 0
    do_reset();
    req = 4'b0100;
    tick();
    rel = 4'b0100; req = '0;
    tick(); rel = '0;
    tick();
    req = 4'b0010;
    tick();
    req = 4'b1111;
    @(negedge clk);
    chk("mid_req", reqx[0], 1'b1);
    chk("mid_gnt", gnt[0], 4'b0010);
    tick(); rst = 1;
    @(negedge clk);
    chk("mid_rst_cycle_req", reqx[0], 1'b0);
    tick(); rst = 0;
    @(negedge clk);
    chk("mid_after_req", reqx[0], 1'b0);
    chk("mid_after_gnt", gnt[0], 4'b0000);
    tick(); @(negedge clk);
    chk("mid_rr_zero", gnt[0], 4'b0001);
    req = '0;
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
